// File: rtl/gray_run_ctrl_pkg.sv
// gray_run_pkg: shared state encodings and default widths for gray_run_ctrl.
package gray_run_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam int STEP_W_DEF = 8;
    localparam int LAP_W_DEF  = 4;
    localparam int CNT_W_DEF  = 3;
endpackage

// File: rtl/gray_run_ctrl_if.sv
// gray_run_ctrl_if: command/status and counter-side signals of gray_run_ctrl.
// fault exists only when GRAY_RUN_CTRL_CHECK_EN is defined.
interface gray_run_ctrl_if import gray_run_pkg::*; #(
    parameter int STEP_W = STEP_W_DEF,
    parameter int LAP_W  = LAP_W_DEF
);
    logic              start;
    logic [STEP_W-1:0] steps;
    logic              pause;
    logic              abort;
    logic              cnt_overflow;
    logic              cnt_en;
    logic              cnt_reset;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] remaining;
    logic [LAP_W-1:0]  laps;
`ifdef GRAY_RUN_CTRL_CHECK_EN
    logic              fault;
    modport master (output start, steps, pause, abort, cnt_overflow,
                    input cnt_en, cnt_reset, busy, done, remaining, laps, fault);
    modport slave  (input start, steps, pause, abort, cnt_overflow,
                    output cnt_en, cnt_reset, busy, done, remaining, laps, fault);
`else
    modport master (output start, steps, pause, abort, cnt_overflow,
                    input cnt_en, cnt_reset, busy, done, remaining, laps);
    modport slave  (input start, steps, pause, abort, cnt_overflow,
                    output cnt_en, cnt_reset, busy, done, remaining, laps);
`endif
endinterface

// File: rtl/gray_run_ctrl_lap_tracker.sv
// gray_lap_tracker: counter phase, saturating lap count and (GRAY_RUN_CTRL_CHECK_EN)
// a sticky check of the counter's overflow flag against the lap count.
module gray_lap_tracker import gray_run_pkg::*; #(
    parameter int LAP_W = LAP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
`ifdef GRAY_RUN_CTRL_CHECK_EN
    input  logic             check,
    input  logic             cnt_overflow,
    output logic             fault,
`endif
    output logic [LAP_W-1:0] laps
);
    logic [CNT_W-1:0] phase;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            laps  <= '0;
        end else if (clear) begin
            phase <= '0;
            laps  <= '0;
        end else if (step) begin
            phase <= phase + 1'b1;
            if (&phase && !(&laps))
                laps <= laps + 1'b1;
        end
    end
`ifdef GRAY_RUN_CTRL_CHECK_EN
    // the counter's overflow and our lap count update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault <= 1'b0;
        else if (clear)
            fault <= 1'b0;
        else if (check && (cnt_overflow != (laps != '0)))
            fault <= 1'b1;
    end
`endif
endmodule

// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl: arms and steps an external 3-bit gray counter for N enabled edges.
// Optional overflow checker with fault output under GRAY_RUN_CTRL_CHECK_EN.
module gray_run_ctrl import gray_run_pkg::*; #(
    parameter int STEP_W = STEP_W_DEF,
    parameter int LAP_W  = LAP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic            clk,
    input logic            rst,
    gray_run_ctrl_if.slave bus
);
    state_t            state, state_nxt;
    logic [STEP_W-1:0] rem, rem_nxt;
    logic              accept, run_step, idle_like, busy_r, done_r;
    assign idle_like     = state == ST_IDLE || state == ST_DONE;
    assign accept        = bus.start && idle_like;
    assign run_step      = state == ST_RUN && !bus.pause && !bus.abort;
    assign bus.cnt_en    = run_step;
    assign bus.cnt_reset = state == ST_SYNC || (state == ST_RUN && bus.abort);
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.remaining = rem;
    always_comb begin
        rem_nxt   = accept ? bus.steps : run_step ? rem - 1'b1 : rem;
        state_nxt = accept ? (bus.steps != '0 ? ST_SYNC : ST_DONE)
                  : idle_like ? ST_IDLE
                  : bus.abort ? ST_IDLE
                  : state == ST_SYNC ? ST_RUN
                  : (run_step && rem == STEP_W'(1)) ? ST_DONE : ST_RUN;
    end
    // status flags are registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rem    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            busy_r <= state_nxt == ST_SYNC || state_nxt == ST_RUN;
            done_r <= state_nxt == ST_DONE;
        end
    end
    gray_lap_tracker #(.LAP_W(LAP_W), .CNT_W(CNT_W)) u_laps (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .step         (run_step),
`ifdef GRAY_RUN_CTRL_CHECK_EN
        .check        (state == ST_RUN || state == ST_DONE),
        .cnt_overflow (bus.cnt_overflow),
        .fault        (bus.fault),
`endif
        .laps         (bus.laps)
    );
endmodule

// File: tb/tb_gray_run_ctrl.sv
// tb_gray_run_ctrl: table-driven and randomized checks of gray_run_ctrl with a
// behavioural gray counter attached.
module tb_gray_run_ctrl;
    import gray_run_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_run_ctrl_if bus ();
    gray_run_ctrl_if #(.LAP_W(2)) bus2 ();
    gray_run_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));
    gray_run_ctrl #(.LAP_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0] g_bin;
    logic       g_ovf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_bin <= '0;
            g_ovf <= 1'b0;
        end else if (bus.cnt_reset) begin
            g_bin <= '0;
            g_ovf <= 1'b0;
        end else if (bus.cnt_en) begin
            g_bin <= g_bin + 1'b1;
            if (g_bin == 3'd7) g_ovf <= 1'b1;
        end
    end
    assign bus.cnt_overflow  = g_ovf;
    assign bus2.cnt_overflow = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input int n, input int p_at, input int p_len, input int ab_at,
                           output int en, output int rs, output int dn, output int run,
                           output int end_busy);
        int  pc;
        bit  fin, ab, in_run;
        logic [31:0] nv;
        pc = 0; fin = 0; en = 0; rs = 0; dn = 0; run = 0;
        nv = n;
        @(negedge clk);
        bus.start = 1'b1; bus.steps = nv[7:0]; bus.pause = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            bus.pause = 1'b0; bus.abort = 1'b0;
            #1;
            in_run = bus.busy && !bus.cnt_reset;
            ab = ab_at != 0 && in_run && en == ab_at;
            bus.abort = ab;
            bus.pause = in_run && pc < p_len && en == p_at;
            if (bus.pause) pc++;
            #1;
            if (bus.cnt_en) en++;
            if (bus.cnt_reset) rs++;
            if (bus.done) dn++;
            if (in_run) run++;
            fin = bus.done || ab;
            if (!fin) @(negedge clk);
        end
        chk("run_finished", int'(fin), 1);
        @(negedge clk);
        bus.pause = 1'b0; bus.abort = 1'b0;
        #1;
        end_busy = bus.busy;
        if (bus.done) dn++;
    endtask

    typedef struct {
        int n, p_at, p_len, ab_at;
        int en, rs, dn, rem, laps, run;
    } vec_t;
    vec_t tab[8];

    initial begin
        int en, rs, dn, run, eb, r5, seen;
        bus.start = 0; bus.steps = '0; bus.pause = 0; bus.abort = 0;
        bus2.start = 0; bus2.steps = '0; bus2.pause = 0; bus2.abort = 0;
        tab[0] = '{5,   0, 0, 0,  5,  1, 1, 0, 0, 5};
        tab[1] = '{20,  0, 0, 0,  20, 1, 1, 0, 2, 20};
        tab[2] = '{10,  4, 3, 0,  10, 1, 1, 0, 1, 13};
        tab[3] = '{12,  0, 0, 4,  4,  2, 0, 8, 0, 5};
        tab[4] = '{0,   0, 0, 0,  0,  0, 1, 0, 0, 0};
        tab[5] = '{300, 0, 0, 0,  44, 1, 1, 0, 5, 44};
        tab[6] = '{8,   0, 0, 0,  8,  1, 1, 0, 1, 8};
        tab[7] = '{1,   0, 0, 0,  1,  1, 1, 0, 0, 1};

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt_en", bus.cnt_en, 0);
        chk("rst_cnt_reset", bus.cnt_reset, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_laps", bus.laps, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_cmd(tab[i].n, tab[i].p_at, tab[i].p_len, tab[i].ab_at, en, rs, dn, run, eb);
            chk($sformatf("v%0d_enables", i), en, tab[i].en);
            chk($sformatf("v%0d_cnt_resets", i), rs, tab[i].rs);
            chk($sformatf("v%0d_done_pulses", i), dn, tab[i].dn);
            chk($sformatf("v%0d_run_cycles", i), run, tab[i].run);
            chk($sformatf("v%0d_remaining", i), bus.remaining, tab[i].rem);
            chk($sformatf("v%0d_laps", i), bus.laps, tab[i].laps);
            chk($sformatf("v%0d_busy_after", i), eb, 0);
            if (i == 1) begin
                chk("gray_output", int'(g_bin ^ (g_bin >> 1)), 6);
                chk("gray_overflow", g_ovf, 1);
`ifdef GRAY_RUN_CTRL_CHECK_EN
                chk("fault_clean", bus.fault, 0);
`endif
            end
        end

        // Start while running is ignored
        en = 0; seen = 0; r5 = 0;
        @(negedge clk);
        bus.start = 1; bus.steps = 8'd10;
        @(negedge clk);
        for (int c = 0; c < 100 && seen == 0; c++) begin
            bus.start = (c == 5); bus.steps = (c == 5) ? 8'd3 : 8'd10;
            #1;
            if (c == 5) r5 = bus.remaining;
            if (c == 6) chk("start_in_run_remaining", bus.remaining, r5 - 1);
            if (bus.cnt_en) en++;
            if (bus.done) seen = 1;
            @(negedge clk);
        end
        bus.start = 0;
        chk("start_in_run_enables", en, 10);
        chk("start_in_run_done", seen, 1);

        // randomized runs against a count-level model
        for (int k = 0; k < 12; k++) begin
            int n, ab, p_at, p_len, x_en;
            n = $urandom_range(0, 40);
            ab = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
            p_at = $urandom_range(0, n);
            p_len = $urandom_range(0, 3);
            x_en = ab != 0 ? ab : n;
            run_cmd(n, p_at, p_len, ab, en, rs, dn, run, eb);
            chk($sformatf("r%0d_enables", k), en, x_en);
            chk($sformatf("r%0d_cnt_resets", k), rs, n == 0 ? 0 : (ab != 0 ? 2 : 1));
            chk($sformatf("r%0d_done_pulses", k), dn, ab != 0 ? 0 : 1);
            chk($sformatf("r%0d_remaining", k), bus.remaining, n - x_en);
            chk($sformatf("r%0d_laps", k), bus.laps, (x_en / 8 > 15) ? 15 : x_en / 8);
        end

        // saturating laps with a 2-bit lap counter
        seen = 0;
        @(negedge clk);
        bus2.start = 1; bus2.steps = 8'd40;
        @(negedge clk);
        bus2.start = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            #1;
            if (bus2.done) seen = 1;
            @(negedge clk);
        end
        chk("lap2_done", seen, 1);
        chk("lap2_laps_sat", bus2.laps, 3);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bus.start = 1; bus.steps = 8'd50;
        @(negedge clk);
        bus.start = 0;
        repeat (12) @(negedge clk);
        #1;
        chk("pre_areset_busy", bus.busy, 1);
        chk("pre_areset_laps", bus.laps, 1);
        #1 rst = 1'b1;
        #1;
        chk("areset_busy", bus.busy, 0);
        chk("areset_cnt_en", bus.cnt_en, 0);
        chk("areset_cnt_reset", bus.cnt_reset, 0);
        chk("areset_done", bus.done, 0);
        chk("areset_remaining", bus.remaining, 0);
        chk("areset_laps", bus.laps, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_run_ctrl.md
Name: gray_run_ctrl

Overview:
- Sequencer for the 3-bit gray counter block (ports Clk/Reset/En/Output/Overflow).
- Accepts a "run N steps" command and arms the counter with a one-cycle reset.
- Drives the counter's En for exactly N enabled clock edges, honouring pause and abort.
- Reports busy/done status and the number of completed counter wraps (laps).
- Sits between the control logic and the counter instance; the counter is external and wired via the Cnt* ports.

Parameters:
- STEP_W, 8: width of the step-count command and of Remaining.
- LAP_W, 4: width of the Laps counter (saturating).
- CNT_W, 3: width of the controlled gray counter; one lap = 2**CNT_W enabled steps.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  command strobe; accepted only in IDLE or DONE.
- Steps  in  STEP_W  number of enabled steps; latched on an accepted Start.
- Pause  in  1  level; while high, CntEn is held low and Remaining is frozen.
- Abort  in  1  level; cancels an active run.
- CntOverflow  in  1  Overflow output of the gray counter (sticky until its reset).
- CntEn  out  1  to counter En.
- CntReset  out  1  to counter Reset.
- Busy  out  1  high in SYNC and RUN.
- Done  out  1  one-cycle pulse, high only in DONE.
- Remaining  out  STEP_W  steps still to be issued.
- Laps  out  LAP_W  completed wraps since the last accepted Start; saturates at all-ones.

Behaviour:
- Reset (async, any time):
  - state = IDLE; Remaining = 0; Laps = 0; phase = 0.
  - Outputs: Busy = 0, Done = 0, CntEn = 0, CntReset = 0.
- States: IDLE, SYNC, RUN, DONE (2-bit encoding; constants live in the shared package).
- IDLE/DONE with Start = 1 at an edge:
  - Latch Remaining = Steps; clear Laps and phase.
  - Next state = SYNC if Steps != 0, else DONE. A zero-step run gives a Done pulse one cycle later and no counter activity.
- IDLE/DONE without Start: next state = IDLE. DONE therefore lasts exactly one cycle unless a new Start is accepted in it.
- SYNC:
  - CntReset = 1 for exactly this one cycle; CntEn = 0.
  - Next state = RUN unconditionally, unless Abort is high, in which case next state = IDLE.
- RUN:
  - CntEn = ~Pause & ~Abort, combinational.
  - On each edge with CntEn = 1: Remaining decrements and phase increments mod 2**CNT_W.
  - When phase wraps from 2**CNT_W-1 to 0, Laps increments (saturating).
  - An edge with CntEn = 1 and Remaining = 1 moves to DONE. A run of N therefore produces exactly N CntEn-high edges.
- Abort in SYNC or RUN (sampled at the edge):
  - CntReset = 1 combinationally in that cycle; CntEn = 0.
  - Next state = IDLE. Remaining and Laps hold their values for inspection.
- Abort in IDLE/DONE is ignored. Start in SYNC/RUN is ignored; Steps is not sampled.
- Start and Abort high together in IDLE/DONE: Start wins.
- Pause and Abort high together in RUN: Abort wins.
- Pause is ignored outside RUN.
- Done = (state == DONE); Busy = (state == SYNC | state == RUN).
- All state, Remaining, Laps and phase are registers; CntEn and CntReset are combinational decodes of state and inputs.

Optional Feature:
- Macro: GRAY_RUN_CTRL_CHECK_EN.
- Defined:
  - Adds output port Fault (1 bit).
  - In RUN and DONE, each cycle compares CntOverflow against the expected value (Laps != 0).
  - On a mismatch, Fault is set and stays sticky.
  - Fault is cleared by Reset or by an accepted Start; it is not checked in IDLE or SYNC.
- Undefined: no Fault port and no checker logic. CntOverflow is present but unused.

Decomposition:
- Package gray_run_pkg holds:
  - state encodings ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_RUN = 2'd2, ST_DONE = 2'd3;
  - default widths STEP_W_DEF = 8, LAP_W_DEF = 4, CNT_W_DEF = 3.
- One natural sub-module: gray_lap_tracker, holding phase, the saturating Laps counter and (under the macro) the Fault checker.
- The FSM and Remaining counter stay in the top level.

Test Plan:
- Reset, then Start with Steps = 5 → CntReset high for 1 cycle; CntEn high for exactly 5 edges; Done pulses once; Remaining = 0; Laps = 0.
- Steps = 20 → Laps = 2 at Done. With the gray counter attached, Output ends at gray(4) = 3'b110, Overflow = 1, and Fault stays 0 (macro on).
- Steps = 10 with Pause high for 3 cycles mid-run → total run length is 13 RUN cycles; exactly 10 CntEn edges.
- Steps = 12 with Abort after 4 enables → state IDLE the next cycle; CntReset pulses; Remaining = 8; Done never asserts.
- Start with Steps = 0 → DONE the next cycle; CntReset and CntEn never assert. A Start issued during RUN is ignored, and Remaining is unaffected.
- Steps = 300 (wraps past 255 as 44) and LAP_W = 2, Steps = 40 → Laps saturates at 3. Async Reset mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
